mem_bus_arbiter: RTL and testbench

- Shares one external memory port between the instruction-fetch requester and the data-memory requester of the MIPS32 core.
- Serializes their transactions and drives the Inst_Stall and data-stall (M_Stall_Controller) inputs of the hazard/stall logic.
- Includes a fairness rule between the two requesters and an optional bus watchdog.

---
 rtl/mem_bus_arbiter_if.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 79 +++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester and shared-memory signals of the fetch/data memory arbiter.
// Ports: none; slave modport is the arbiter side, master modport is the requesters plus memory side.
interface mem_bus_arbiter_if;
    logic        InstReq;
    logic [29:0] InstAddr;
    logic [31:0] InstData;
    logic        InstReady;
    logic        DataRead;
    logic        DataWrite;
    logic [29:0] DataAddr;
    logic [31:0] DataWriteData;
    logic [3:0]  DataByteEn;
    logic [31:0] DataReadData;
    logic        DataReady;
    logic        BusError;
    logic [29:0] MemAddr;
    logic [31:0] MemWriteData;
    logic [3:0]  MemByteEn;
    logic        MemRead;
    logic        MemWrite;
    logic        MemReady;
    logic [31:0] MemReadData;
    logic        Inst_Stall;
    logic        Data_Stall;
    modport slave (
        input  InstReq, InstAddr, DataRead, DataWrite, DataAddr, DataWriteData, DataByteEn,
               MemReady, MemReadData,
        output InstData, InstReady, DataReadData, DataReady, BusError, MemAddr, MemWriteData,
               MemByteEn, MemRead, MemWrite, Inst_Stall, Data_Stall
    );
    modport master (
        output InstReq, InstAddr, DataRead, DataWrite, DataAddr, DataWriteData, DataByteEn,
               MemReady, MemReadData,
        input  InstData, InstReady, DataReadData, DataReady, BusError, MemAddr, MemWriteData,
               MemByteEn, MemRead, MemWrite, Inst_Stall, Data_Stall
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between instruction fetch and data access, alternating on ties.
// Ports: clock (rising edge), reset (async active-low), bus (mem_bus_arbiter_if.slave: requests, memory port, stalls).
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic              clock,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY} state_t;
    localparam bit          WD_EN   = TIMEOUT_CYCLES > 0;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t      state;
    logic        last_data;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rd_q;
    logic        wr_q;
    logic [15:0] cnt;
    logic        inst_pend;
    logic        data_pend;
    logic        grant_data;
    logic        busy;
    logic        timeout;
    logic        done;
    logic        inst_rdy;
    logic        data_rdy;
    assign inst_pend  = bus.InstReq;
    assign data_pend  = bus.DataRead | bus.DataWrite;
    // on a tie the requester that was not served last wins; reset leaves INST as last so data goes first
    assign grant_data = data_pend & (~inst_pend | ~last_data);
    assign busy       = state != IDLE;
    // watchdog fires on the last allowed busy cycle only if the memory has not answered in it
    assign timeout    = WD_EN && busy && !bus.MemReady && cnt == WD_LAST;
    assign done       = busy & (bus.MemReady | timeout);
    assign inst_rdy   = done & (state == INST_BUSY);
    assign data_rdy   = done & (state == DATA_BUSY);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_data <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt       <= '0;
        end else if (!busy && (inst_pend | data_pend)) begin
            state     <= grant_data ? DATA_BUSY : INST_BUSY;
            last_data <= grant_data;
            addr_q    <= grant_data ? bus.DataAddr : bus.InstAddr;
            wdata_q   <= grant_data ? bus.DataWriteData : 32'h0;
            be_q      <= grant_data ? bus.DataByteEn : 4'hF;
            // a data grant implies DataRead|DataWrite, so ~DataWrite here means a pure load
            rd_q      <= ~grant_data | ~bus.DataWrite;
            wr_q      <= grant_data & bus.DataWrite;
            cnt       <= '0;
        end else if (busy && done) begin
            state <= IDLE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 16'd1;
        end
    end
    assign bus.MemAddr      = addr_q;
    assign bus.MemWriteData = wdata_q;
    assign bus.MemByteEn    = be_q;
    assign bus.MemRead      = rd_q;
    assign bus.MemWrite     = wr_q;
    assign bus.InstReady    = inst_rdy;
    assign bus.DataReady    = data_rdy;
    assign bus.BusError     = timeout;
    assign bus.InstData     = (inst_rdy & bus.MemReady) ? bus.MemReadData : 32'h0;
    assign bus.DataReadData = (data_rdy & bus.MemReady) ? bus.MemReadData : 32'h0;
    assign bus.Inst_Stall   = inst_pend & ~inst_rdy;
    assign bus.Data_Stall   = data_pend & ~data_rdy;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scenario tasks plus randomized traffic against a transaction-level arbitration model.
module tb_mem_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   last_data_m;
    mem_bus_arbiter_if b();
    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(b));
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        b.InstReq = 0; b.InstAddr = 0; b.DataRead = 0; b.DataWrite = 0; b.DataAddr = 0;
        b.DataWriteData = 0; b.DataByteEn = 0; b.MemReady = 0; b.MemReadData = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
        last_data_m = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        b.InstReq = 1; b.DataWrite = 1; b.MemReady = 1; b.MemReadData = 32'hFFFF_FFFF;
        tick();
        checks++;
        if ({b.InstData, b.InstReady, b.DataReadData, b.DataReady, b.BusError, b.MemAddr,
             b.MemWriteData, b.MemByteEn, b.MemRead, b.MemWrite} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rd=%b wr=%b ir=%b dr=%b addr=%h required all zero",
                     b.MemRead, b.MemWrite, b.InstReady, b.DataReady, b.MemAddr);
        end
        checks++;
        if ({b.Inst_Stall, b.Data_Stall} !== 2'b11) begin
            failures++;
            $display("FAIL reset_stalls got %b required 11", {b.Inst_Stall, b.Data_Stall});
        end
    endtask

    task automatic test_fetch();
        logic [31:0] d;
        do_reset();
        d = $urandom;
        b.InstReq = 1; b.InstAddr = 30'h100; b.MemReady = 1; b.MemReadData = d;
        #1;
        checks++;
        if ({b.Inst_Stall, b.MemRead, b.InstReady} !== 3'b100) begin
            failures++;
            $display("FAIL fetch_cycle0 got stall/rd/rdy=%b required 100", {b.Inst_Stall, b.MemRead, b.InstReady});
        end
        tick();
        checks++;
        if ({b.MemRead, b.MemAddr, b.MemByteEn, b.MemWriteData} !== {1'b1, 30'h100, 4'hF, 32'h0}) begin
            failures++;
            $display("FAIL fetch_bus got rd=%b addr=%h be=%h wd=%h required 1 100 f 0",
                     b.MemRead, b.MemAddr, b.MemByteEn, b.MemWriteData);
        end
        checks++;
        if ({b.InstReady, b.InstData, b.Inst_Stall} !== {1'b1, d, 1'b0}) begin
            failures++;
            $display("FAIL fetch_ready got rdy=%b data=%h stall=%b required 1 %h 0",
                     b.InstReady, b.InstData, b.Inst_Stall, d);
        end
        tick();
        b.InstReq = 0;
        #1;
        checks++;
        if ({b.MemRead, b.InstReady, b.Inst_Stall} !== 3'b000) begin
            failures++;
            $display("FAIL fetch_after got %b required 000", {b.MemRead, b.InstReady, b.Inst_Stall});
        end
    endtask

    task automatic test_write_stable();
        int pulses;
        do_reset();
        b.DataWrite = 1; b.DataAddr = 30'h20; b.DataWriteData = 32'hDEADBEEF; b.DataByteEn = 4'b0011;
        #1;
        checks++;
        if ({b.Data_Stall, b.MemWrite} !== 2'b10) begin
            failures++;
            $display("FAIL write_idle got stall/wr=%b required 10", {b.Data_Stall, b.MemWrite});
        end
        pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            b.MemReady = (c == 3);
            b.MemReadData = $urandom;
            if (c > 1) begin
                b.DataAddr = 30'($urandom); b.DataWriteData = $urandom; b.DataByteEn = 4'($urandom);
            end
            #1;
            checks++;
            if ({b.MemWrite, b.MemRead, b.MemAddr, b.MemWriteData, b.MemByteEn} !==
                {2'b10, 30'h20, 32'hDEADBEEF, 4'b0011}) begin
                failures++;
                $display("FAIL write_bus c=%0d got wr=%b rd=%b addr=%h wd=%h be=%b required 1 0 20 deadbeef 0011",
                         c, b.MemWrite, b.MemRead, b.MemAddr, b.MemWriteData, b.MemByteEn);
            end
            checks++;
            if ({b.DataReady, b.Data_Stall, b.BusError} !== {c == 3, c != 3, 1'b0}) begin
                failures++;
                $display("FAIL write_handshake c=%0d got rdy/stall/err=%b required %b",
                         c, {b.DataReady, b.Data_Stall, b.BusError}, {c == 3, c != 3, 1'b0});
            end
            pulses += int'(b.DataReady);
        end
        tick();
        b.DataWrite = 0; b.MemReady = 0;
        #1;
        pulses += int'(b.DataReady);
        checks++;
        if ({b.MemWrite, b.Data_Stall} !== 2'b00 || pulses != 1) begin
            failures++;
            $display("FAIL write_end got wr=%b stall=%b pulses=%0d required 0 0 1", b.MemWrite, b.Data_Stall, pulses);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        b.InstReq = 1; b.InstAddr = 30'($urandom); b.MemReadData = $urandom | 32'h1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if ({b.MemRead, b.InstReady, b.BusError, b.InstData, b.Inst_Stall} !==
                {1'b1, c == 4, c == 4, 32'h0, c != 4}) begin
                failures++;
                $display("FAIL timeout c=%0d got rd=%b rdy=%b err=%b data=%h stall=%b",
                         c, b.MemRead, b.InstReady, b.BusError, b.InstData, b.Inst_Stall);
            end
        end
        tick();
        b.InstReq = 0;
        #1;
        checks++;
        if ({b.MemRead, b.InstReady, b.BusError} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_idle got %b required 000", {b.MemRead, b.InstReady, b.BusError});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b.DataWrite = 1; b.DataAddr = 30'h33; b.DataWriteData = $urandom; b.DataByteEn = 4'hF;
        tick();
        tick();
        checks++;
        if (b.MemWrite !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre got wr=%b required 1", b.MemWrite);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({b.MemWrite, b.MemRead, b.DataReady, b.MemAddr} !== '0) begin
            failures++;
            $display("FAIL midreset_drop got wr=%b rd=%b rdy=%b addr=%h required all zero",
                     b.MemWrite, b.MemRead, b.DataReady, b.MemAddr);
        end
        b.DataWrite = 0; b.DataRead = 1; b.DataAddr = 30'h44; b.InstReq = 1; b.InstAddr = 30'h55;
        #3;
        reset = 1'b1;
        last_data_m = 1'b0;
        tick();
        checks++;
        if ({b.MemRead, b.MemWrite, b.MemAddr} !== {2'b10, 30'h44}) begin
            failures++;
            $display("FAIL midreset_tie got rd=%b wr=%b addr=%h required 1 0 44", b.MemRead, b.MemWrite, b.MemAddr);
        end
        b.MemReady = 1;
        #1;
        checks++;
        if ({b.DataReady, b.InstReady} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_ready got %b required 10", {b.DataReady, b.InstReady});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_both_rw();
        do_reset();
        b.DataRead = 1; b.DataWrite = 1; b.DataAddr = 30'($urandom);
        tick();
        checks++;
        if ({b.MemWrite, b.MemRead} !== 2'b10) begin
            failures++;
            $display("FAIL both_rw got wr/rd=%b required 10", {b.MemWrite, b.MemRead});
        end
        b.MemReady = 1;
        #1;
        checks++;
        if (b.DataReady !== 1'b1) begin
            failures++;
            $display("FAIL both_rw_ready got %b required 1", b.DataReady);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_traffic(input int n, input bit force_ties);
        bit ip, dp, gd, drd, dwr, mr, done, err;
        int op, ready_at;
        logic [29:0] ia, da;
        logic [31:0] dw, rd;
        logic [3:0] be;
        logic [67:0] exp_bus;
        do_reset();
        ip = 0; dp = 0; drd = 0; dwr = 0; ia = 0; da = 0; dw = 0; be = 0;
        for (int t = 0; t < n; t++) begin
            if (!ip && (force_ties || $urandom_range(0, 1) == 1)) begin
                ip = 1; ia = 30'($urandom);
            end
            if (!dp && (force_ties || $urandom_range(0, 1) == 1)) begin
                dp = 1; da = 30'($urandom); dw = $urandom; be = 4'($urandom);
                op = $urandom_range(0, 2); drd = op != 1; dwr = op != 0;
            end
            if (!ip && !dp) begin
                ip = 1; ia = 30'($urandom);
            end
            b.InstReq = ip; b.InstAddr = ia; b.DataRead = dp & drd; b.DataWrite = dp & dwr;
            b.DataAddr = da; b.DataWriteData = dw; b.DataByteEn = be;
            b.MemReady = 1'($urandom_range(0, 1)); b.MemReadData = $urandom;
            #1;
            checks++;
            if ({b.MemRead, b.MemWrite, b.InstReady, b.DataReady, b.BusError, b.Inst_Stall, b.Data_Stall} !==
                {5'b0, ip, dp}) begin
                failures++;
                $display("FAIL traffic_idle t=%0d got %b required %b", t,
                         {b.MemRead, b.MemWrite, b.InstReady, b.DataReady, b.BusError, b.Inst_Stall, b.Data_Stall},
                         {5'b0, ip, dp});
            end
            gd = dp && (!ip || !last_data_m);
            last_data_m = gd;
            exp_bus = gd ? {da, dw, be, drd & ~dwr, dwr} : {ia, 32'h0, 4'hF, 1'b1, 1'b0};
            ready_at = $urandom_range(0, force_ties ? 2 : 5) + 1;
            for (int c = 1; c <= 4; c++) begin
                tick();
                mr = c == ready_at;
                rd = $urandom;
                b.MemReady = mr; b.MemReadData = rd;
                #1;
                done = mr || c == 4;
                err = !mr && c == 4;
                checks++;
                if ({b.MemAddr, b.MemWriteData, b.MemByteEn, b.MemRead, b.MemWrite} !== exp_bus) begin
                    failures++;
                    $display("FAIL traffic_bus t=%0d c=%0d got %h required %h", t, c,
                             {b.MemAddr, b.MemWriteData, b.MemByteEn, b.MemRead, b.MemWrite}, exp_bus);
                end
                checks++;
                if ({b.InstReady, b.DataReady, b.BusError} !== {!gd && done, gd && done, err}) begin
                    failures++;
                    $display("FAIL traffic_ready t=%0d c=%0d got %b required %b", t, c,
                             {b.InstReady, b.DataReady, b.BusError}, {!gd && done, gd && done, err});
                end
                checks++;
                if ({b.InstData, b.DataReadData} !== {(!gd && mr) ? rd : 32'h0, (gd && mr) ? rd : 32'h0}) begin
                    failures++;
                    $display("FAIL traffic_data t=%0d c=%0d got %h %h", t, c, b.InstData, b.DataReadData);
                end
                checks++;
                if ({b.Inst_Stall, b.Data_Stall} !== {ip && !(done && !gd), dp && !(done && gd)}) begin
                    failures++;
                    $display("FAIL traffic_stall t=%0d c=%0d got %b required %b", t, c,
                             {b.Inst_Stall, b.Data_Stall}, {ip && !(done && !gd), dp && !(done && gd)});
                end
                if (done) break;
            end
            tick();
            b.MemReady = 0;
            if (gd) dp = 0;
            else ip = 0;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_write_stable();
        test_timeout();
        test_reset_mid();
        test_both_rw();
        test_traffic(8, 1'b1);
        test_traffic(40, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
